// File: rtl/present_ctrl_if.sv
// Host-side handshake bundle for present_ctrl: key load, block command and result return.
// master = command source, slave = controller.
interface present_ctrl_if;
  logic [79:0] key_i;
  logic        key_valid_i;
  logic        key_ready_o;
  logic [63:0] in_block_i;
  logic        in_encdec_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [63:0] out_block_o;
  logic        out_err_o;
  logic        out_valid_o;
  logic        out_ready_i;

  modport master (
    output key_i, key_valid_i, in_block_i, in_encdec_i, in_valid_i, out_ready_i,
    input  key_ready_o, in_ready_o, out_block_o, out_err_o, out_valid_o
  );

  modport slave (
    input  key_i, key_valid_i, in_block_i, in_encdec_i, in_valid_i, out_ready_i,
    output key_ready_o, in_ready_o, out_block_o, out_err_o, out_valid_o
  );
endinterface

// File: rtl/present_ctrl.sv
// Sequences one PRESENT-80 core operation per block: core reset, key schedule, done flag, result.
// Latency RST_CYCLES + core latency + 2 cycles to out_valid; host stalls via in_ready/out_ready.
module present_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic          clk,
  input  logic          rst,
  present_ctrl_if.slave host,
  output logic          busy_o,
  output logic          key_loaded_o,
  output logic [31:0]   blk_count_o,
  output logic          core_rst_o,
  output logic          core_encdec_o,
  output logic [79:0]   core_key_o,
  output logic [63:0]   core_block_o,
  input  logic          core_end_key_i,
  input  logic [63:0]   core_block_i,
  input  logic          core_end_enc_i,
  input  logic          core_end_dec_i
);

  // One counter serves the core-reset hold and the watchdog; they never overlap.
  localparam int CMAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_CORE,
    S_WAIT_KEY,
    S_WAIT_DONE,
    S_OUT
  } state_e;

  typedef struct packed {
    logic        encdec;
    logic [63:0] blk;
  } op_t;

  typedef struct packed {
    logic        err;
    logic [63:0] blk;
  } res_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [79:0]   key_q, key_d;
  logic          key_loaded_q, key_loaded_d;
  op_t           op_q, op_d;
  res_t          res_q, res_d;
  logic [31:0]   blk_count_q, blk_count_d;
  logic          done_match;

  // Only the flag for the latched direction counts; the other is ignored.
  assign done_match = op_q.encdec ? core_end_dec_i : core_end_enc_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      key_q        <= '0;
      key_loaded_q <= 1'b0;
      op_q         <= '0;
      res_q        <= '0;
      blk_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      key_q        <= key_d;
      key_loaded_q <= key_loaded_d;
      op_q         <= op_d;
      res_q        <= res_d;
      blk_count_q  <= blk_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    key_d        = key_q;
    key_loaded_d = key_loaded_q;
    op_d         = op_q;
    res_d        = res_q;
    blk_count_d  = blk_count_q;

    case (state_q)
      S_IDLE: begin
        if (host.key_valid_i) begin
          key_d        = host.key_i;
          key_loaded_d = 1'b1;
        end else if (host.in_valid_i && key_loaded_q) begin
          op_d.encdec = host.in_encdec_i;
          op_d.blk    = host.in_block_i;
          cnt_d       = '0;
          state_d     = S_RST_CORE;
        end
      end

      S_RST_CORE: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT_KEY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Watchdog wins here so the counter can never run past its terminal value.
      S_WAIT_KEY: begin
        if (cnt_q == TMO_LAST) begin
          res_d.err = 1'b1;
          res_d.blk = '0;
          state_d   = S_OUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (core_end_key_i) begin
            state_d = S_WAIT_DONE;
          end
        end
      end

      S_WAIT_DONE: begin
        if (done_match) begin
          res_d.err = 1'b0;
          res_d.blk = core_block_i;
          state_d   = S_OUT;
        end else if (cnt_q == TMO_LAST) begin
          res_d.err = 1'b1;
          res_d.blk = '0;
          state_d   = S_OUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_OUT: begin
        if (host.out_ready_i) begin
          state_d = S_IDLE;
          if (!res_q.err) begin
            blk_count_d = blk_count_q + 32'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // A pending key load takes the cycle, so the block command waits one cycle.
  assign host.key_ready_o = (state_q == S_IDLE);
  assign host.in_ready_o  = (state_q == S_IDLE) & key_loaded_q & ~host.key_valid_i;
  assign host.out_valid_o = (state_q == S_OUT);
  assign host.out_block_o = res_q.blk;
  assign host.out_err_o   = res_q.err;

  assign busy_o        = (state_q != S_IDLE);
  assign key_loaded_o  = key_loaded_q;
  assign blk_count_o   = blk_count_q;
  assign core_rst_o    = !((state_q == S_WAIT_KEY) || (state_q == S_WAIT_DONE));
  assign core_encdec_o = op_q.encdec;
  assign core_key_o    = key_q;
  assign core_block_o  = op_q.blk;

endmodule

// File: tb/tb_present_ctrl.sv
// Bench for present_ctrl with a behavioural PRESENT-80 core and a result scoreboard.
module tb_present_ctrl;
  localparam int RST_CYCLES = 2;
  localparam int TIMEOUT    = 16;
  localparam int KEY_LAT    = 3;
  localparam int DAT_LAT    = 4;

  typedef struct {
    logic [63:0] blk;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        busy, key_loaded, core_rst, core_encdec;
  logic [31:0] blk_count;
  logic [79:0] core_key;
  logic [63:0] core_blk_in, core_res;
  logic        end_key, end_enc, end_dec;
  bit          core_hang, core_swap;
  int          core_cnt;
  int          n_vec, n_err, exp_count;
  exp_t        sb[$];

  present_ctrl_if hif ();

  present_ctrl #(.RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .host           (hif),
    .busy_o         (busy),
    .key_loaded_o   (key_loaded),
    .blk_count_o    (blk_count),
    .core_rst_o     (core_rst),
    .core_encdec_o  (core_encdec),
    .core_key_o     (core_key),
    .core_block_o   (core_blk_in),
    .core_end_key_i (end_key),
    .core_block_i   (core_res),
    .core_end_enc_i (end_enc),
    .core_end_dec_i (end_dec)
  );

  always begin
    clk = 1'b0; #5;
    clk = 1'b1; #5;
  end

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h21748FE3DA09B65C;
    return t[x*4 +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] r;
    r = '0;
    for (int y = 0; y < 16; y++) if (sbox(4'(y)) == x) r = 4'(y);
    return r;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] s, input bit inv);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      int p;
      p = (i == 63) ? 63 : (i * 16) % 63;
      if (inv) o[i] = s[p];
      else     o[p] = s[i];
    end
    return o;
  endfunction

  function automatic logic [63:0] present_crypt(input logic [79:0] key, input logic [63:0] blk, input bit dec);
    logic [79:0] k;
    logic [63:0] rk [1:32];
    logic [63:0] s;
    k = key;
    for (int r = 1; r <= 32; r++) begin
      rk[r] = k[79:16];
      k = {k[18:0], k[79:19]};
      k[79:76] = sbox(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    s = blk;
    if (!dec) begin
      for (int r = 1; r <= 31; r++) begin
        s = s ^ rk[r];
        for (int n = 0; n < 16; n++) s[n*4 +: 4] = sbox(s[n*4 +: 4]);
        s = p_layer(s, 1'b0);
      end
      s = s ^ rk[32];
    end else begin
      s = s ^ rk[32];
      for (int r = 31; r >= 1; r--) begin
        s = p_layer(s, 1'b1);
        for (int n = 0; n < 16; n++) s[n*4 +: 4] = inv_sbox(s[n*4 +: 4]);
        s = s ^ rk[r];
      end
    end
    return s;
  endfunction

  // Core model: key schedule KEY_LAT cycles after reset release, result DAT_LAT later, flags held.
  always @(posedge clk) begin
    if (core_rst !== 1'b0) begin
      core_cnt <= 0;
      end_key  <= 1'b0;
      end_enc  <= 1'b0;
      end_dec  <= 1'b0;
      core_res <= '0;
    end else begin
      core_cnt <= core_cnt + 1;
      if (!core_hang && core_cnt == KEY_LAT - 1) end_key <= 1'b1;
      if (!core_hang && core_cnt == KEY_LAT + DAT_LAT - 1) begin
        core_res <= present_crypt(core_key, core_blk_in, core_encdec);
        if (core_encdec ^ core_swap) end_dec <= 1'b1;
        else                         end_enc <= 1'b1;
      end
    end
  end

  task automatic load_key(input logic [79:0] k);
    hif.key_i = k;
    hif.key_valid_i = 1'b1;
    @(negedge clk);
    hif.key_valid_i = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] b, input logic e, output bit ok);
    int n;
    hif.in_block_i = b;
    hif.in_encdec_i = e;
    hif.in_valid_i = 1'b1;
    #1;
    n = 0;
    while (hif.in_ready_o !== 1'b1 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    ok = (hif.in_ready_o === 1'b1);
    @(posedge clk);
    @(negedge clk);
    hif.in_valid_i = 1'b0;
  endtask

  task automatic get_result(output logic [63:0] b, output logic e, output bit ok);
    int n;
    n = 0;
    while (hif.out_valid_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (hif.out_valid_o === 1'b1);
    b = hif.out_block_o;
    e = hif.out_err_o;
    if (ok) begin
      hif.out_ready_i = 1'b1;
      @(negedge clk);
      hif.out_ready_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    n_vec += 7;
    if (core_rst !== 1'b1) begin n_err++; $display("FAIL reset_core_rst: got %b want 1", core_rst); end
    if (hif.out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", hif.out_valid_o); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (key_loaded !== 1'b0) begin n_err++; $display("FAIL reset_key_loaded: got %b want 0", key_loaded); end
    if (blk_count !== 32'd0) begin n_err++; $display("FAIL reset_blk_count: got %0d want 0", blk_count); end
    if (hif.in_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", hif.in_ready_o); end
    if (hif.key_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_key_ready: got %b want 1", hif.key_ready_o); end
    rst = 1'b1;
    exp_count = 0;
    @(negedge clk);
  endtask

  task automatic test_key_priority();
    bit bad;
    int n;
    logic [63:0] b;
    logic e;
    bit ok;
    exp_t x;
    bad = 0;
    hif.in_block_i = '0;
    hif.in_encdec_i = 1'b0;
    hif.in_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (hif.in_ready_o !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    n_vec++;
    if (bad) begin n_err++; $display("FAIL no_key_block: in_ready=%b busy=%b want 0/0", hif.in_ready_o, busy); end
    hif.key_i = '0;
    hif.key_valid_i = 1'b1;
    #1;
    n_vec += 2;
    if (hif.in_ready_o !== 1'b0) begin n_err++; $display("FAIL key_priority_in_ready: got %b want 0", hif.in_ready_o); end
    if (hif.key_ready_o !== 1'b1) begin n_err++; $display("FAIL key_priority_key_ready: got %b want 1", hif.key_ready_o); end
    @(negedge clk);
    hif.key_valid_i = 1'b0;
    #1;
    n_vec += 2;
    if (key_loaded !== 1'b1) begin n_err++; $display("FAIL key_loaded: got %b want 1", key_loaded); end
    if (hif.in_ready_o !== 1'b1) begin n_err++; $display("FAIL block_after_key: in_ready=%b want 1", hif.in_ready_o); end
    sb.push_back('{64'h5579C1387B228445, 1'b0});
    @(posedge clk);
    @(negedge clk);
    hif.in_valid_i = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL busy_after_cmd: got %b want 1", busy); end
    n = 0;
    while (core_rst === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    n_vec++;
    if (n != RST_CYCLES) begin n_err++; $display("FAIL core_rst_hold: got %0d cycles want %0d", n, RST_CYCLES); end
    get_result(b, e, ok);
    x = sb.pop_front();
    exp_count++;
    n_vec += 2;
    if (!ok || b !== x.blk || e !== x.err) begin
      n_err++; $display("FAIL key0_enc: blk=%h err=%b valid=%b want blk=%h err=%b", b, e, ok, x.blk, x.err);
    end
    if (blk_count !== 32'(exp_count)) begin n_err++; $display("FAIL key0_count: got %0d want %0d", blk_count, exp_count); end
  endtask

  task automatic test_ff_vectors();
    logic [63:0] b;
    logic e;
    bit ok;
    exp_t x;
    logic [63:0] din  [2];
    logic [63:0] dexp [2];
    din[0] = 64'hFFFFFFFFFFFFFFFF; dexp[0] = 64'h3333DCD3213210D2;
    din[1] = 64'h3333DCD3213210D2; dexp[1] = 64'hFFFFFFFFFFFFFFFF;
    load_key(80'hFFFFFFFFFFFFFFFFFFFF);
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{dexp[i], 1'b0});
      send_block(din[i], 1'(i), ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL ff_accept[%0d]: in_ready=%b want 1", i, hif.in_ready_o); end
      get_result(b, e, ok);
      x = sb.pop_front();
      exp_count++;
      n_vec += 2;
      if (!ok || b !== x.blk || e !== x.err) begin
        n_err++; $display("FAIL ff_vec[%0d]: blk=%h err=%b valid=%b want blk=%h err=%b", i, b, e, ok, x.blk, x.err);
      end
      if (blk_count !== 32'(exp_count)) begin n_err++; $display("FAIL ff_count[%0d]: got %0d want %0d", i, blk_count, exp_count); end
    end
  endtask

  task automatic test_back_to_back();
    logic [79:0] k;
    logic [63:0] pt, ct, b;
    logic e;
    bit ok;
    exp_t x;
    k = {$urandom(), $urandom(), 16'($urandom())};
    load_key(k);
    pt = '0; ct = '0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        pt = {$urandom(), $urandom()};
        ct = present_crypt(k, pt, 1'b0);
        sb.push_back('{ct, 1'b0});
        send_block(pt, 1'b0, ok);
      end else begin
        sb.push_back('{pt, 1'b0});
        send_block(ct, 1'b1, ok);
      end
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL b2b_accept[%0d]: in_ready=%b want 1", i, hif.in_ready_o); end
      get_result(b, e, ok);
      x = sb.pop_front();
      exp_count++;
      n_vec += 2;
      if (!ok || b !== x.blk || e !== x.err) begin
        n_err++; $display("FAIL b2b[%0d]: blk=%h err=%b valid=%b want blk=%h err=%b", i, b, e, ok, x.blk, x.err);
      end
      if (hif.in_ready_o !== 1'b1 || busy !== 1'b0) begin
        n_err++; $display("FAIL b2b_idle[%0d]: in_ready=%b busy=%b want 1/0", i, hif.in_ready_o, busy);
      end
    end
    n_vec++;
    if (blk_count !== 32'(exp_count)) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", blk_count, exp_count); end
  endtask

  task automatic test_timeout();
    logic [63:0] b;
    logic e;
    bit ok;
    exp_t x;
    int n;
    for (int m = 0; m < 2; m++) begin
      core_hang = (m == 0);
      core_swap = (m == 1);
      sb.push_back('{64'h0, 1'b1});
      send_block({$urandom(), $urandom()}, 1'(m), ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL tmo_accept[%0d]: in_ready=%b want 1", m, hif.in_ready_o); end
      n = 0;
      while (core_rst === 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      n = 1;
      while (hif.out_valid_o !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      n_vec++;
      if (n != TIMEOUT + 1) begin n_err++; $display("FAIL tmo_latency[%0d]: got cycle %0d want %0d", m, n, TIMEOUT + 1); end
      get_result(b, e, ok);
      x = sb.pop_front();
      n_vec += 2;
      if (!ok || b !== x.blk || e !== x.err) begin
        n_err++; $display("FAIL tmo_result[%0d]: blk=%h err=%b valid=%b want blk=%h err=%b", m, b, e, ok, x.blk, x.err);
      end
      if (blk_count !== 32'(exp_count)) begin n_err++; $display("FAIL tmo_count[%0d]: got %0d want %0d", m, blk_count, exp_count); end
    end
    core_hang = 0;
    core_swap = 0;
  endtask

  task automatic test_hold();
    logic [63:0] pt, b;
    logic e;
    bit ok, bad;
    exp_t x;
    int n;
    pt = {$urandom(), $urandom()};
    load_key(80'h0);
    sb.push_back('{present_crypt(80'h0, pt, 1'b0), 1'b0});
    send_block(pt, 1'b0, ok);
    n = 0;
    while (hif.out_valid_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (hif.out_valid_o !== 1'b1 || hif.out_block_o !== sb[0].blk ||
          hif.in_ready_o !== 1'b0 || core_rst !== 1'b1) bad = 1;
      @(negedge clk);
    end
    n_vec++;
    if (bad) begin
      n_err++; $display("FAIL hold: valid=%b blk=%h in_ready=%b core_rst=%b want 1/%h/0/1",
                        hif.out_valid_o, hif.out_block_o, hif.in_ready_o, core_rst, sb[0].blk);
    end
    get_result(b, e, ok);
    x = sb.pop_front();
    exp_count++;
    n_vec += 2;
    if (!ok || b !== x.blk || e !== x.err) begin
      n_err++; $display("FAIL hold_result: blk=%h err=%b valid=%b want blk=%h err=%b", b, e, ok, x.blk, x.err);
    end
    if (busy !== 1'b0 || hif.out_valid_o !== 1'b0) begin
      n_err++; $display("FAIL hold_release: busy=%b valid=%b want 0/0", busy, hif.out_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, bad;
    int n;
    send_block({$urandom(), $urandom()}, 1'b0, ok);
    n = 0;
    while (end_key !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_count = 0;
    n_vec += 5;
    if (core_rst !== 1'b1) begin n_err++; $display("FAIL mid_rst_core_rst: got %b want 1", core_rst); end
    if (key_loaded !== 1'b0) begin n_err++; $display("FAIL mid_rst_key_loaded: got %b want 0", key_loaded); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    if (hif.out_valid_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", hif.out_valid_o); end
    if (blk_count !== 32'd0) begin n_err++; $display("FAIL mid_rst_count: got %0d want 0", blk_count); end
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hif.out_valid_o !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    n_vec++;
    if (bad) begin n_err++; $display("FAIL mid_rst_quiet: valid=%b busy=%b want 0/0", hif.out_valid_o, busy); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_count = 0;
    core_hang = 0;
    core_swap = 0;
    rst = 1'b0;
    hif.key_i = '0;
    hif.key_valid_i = 1'b0;
    hif.in_block_i = '0;
    hif.in_encdec_i = 1'b0;
    hif.in_valid_i = 1'b0;
    hif.out_ready_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_key_priority();
    test_ff_vectors();
    test_back_to_back();
    test_timeout();
    test_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
